// File: rtl/ycfsm_pkg.sv
// Shared definitions for the ycfsm column driver: dual-rail codes, FSM states
// and error codes.
package ycfsm_pkg;

  localparam logic [1:0] DR_EMPTY   = 2'b00;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CAPTURE,
    ST_CLEAR,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_ILLEGAL = 2'b10
  } err_code_t;

  function automatic logic [1:0] dr_encode(input logic b);
    return b ? DR_ONE : DR_ZERO;
  endfunction

endpackage

// File: rtl/dr_sync.sv
// Multi-stage synchronizer that brings the asynchronous column outputs into
// the clk domain.
module dr_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  // NOTE: every stage is reset so the synchronized pairs read empty, not X,
  // as soon as reset asserts; this array is tiny flops, not a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/ycfsm_driver.sv
// Clocked host-side driver for a column of asynchronous ycfsm cells: encodes
// words to dual-rail, runs the four-phase return-to-empty handshake.
module ycfsm_driver
  import ycfsm_pkg::*;
#(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  output logic [2*N-1:0] vin,
  input  logic [2*N-1:0] vout,
  output logic           res_valid,
  output logic [N-1:0]   res_data,
  output logic           err,
  output logic [1:0]     err_code,
  input  logic           clear_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          r_state, w_state_next;
  err_code_t       r_err_code, w_err_code_next;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_vin;
  logic            r_res_valid;
  logic [N-1:0]    r_res_data;

  logic [2*N-1:0]  w_svout;
  logic [2*N-1:0]  w_enc;
  logic [N-1:0]    w_result;
  logic            w_all_empty, w_all_valid, w_any_illegal, w_timeout, w_in_ready;

  dr_sync #(.WIDTH(2*N), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (vout),
    .o_q   (w_svout)
  );

  // NOTE: every flag gets its default before the loop, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_all_empty   = 1'b1;
    w_all_valid   = 1'b1;
    w_any_illegal = 1'b0;
    w_result      = '0;
    w_enc         = '0;
    for (int i = 0; i < N; i++) begin
      if (w_svout[2*i +: 2] != DR_EMPTY) w_all_empty = 1'b0;
      if (w_svout[2*i +: 2] == DR_EMPTY || w_svout[2*i +: 2] == DR_ILLEGAL) w_all_valid = 1'b0;
      if (w_svout[2*i +: 2] == DR_ILLEGAL) w_any_illegal = 1'b1;
      w_result[i]      = w_svout[2*i+1];
      w_enc[2*i +: 2]  = dr_encode(in_data[i]);
    end
  end

  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_in_ready = (r_state == ST_IDLE) && w_all_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_next;
      r_err_code <= w_err_code_next;
    end
  end

  // Illegal pairs outrank every other transition, including a timeout.
  always_comb begin
    w_state_next    = r_state;
    w_err_code_next = r_err_code;
    if (w_any_illegal && r_state != ST_ERROR) begin
      w_state_next    = ST_ERROR;
      w_err_code_next = ERR_ILLEGAL;
    end else begin
      case (r_state)
        ST_IDLE:    if (in_valid && w_in_ready) w_state_next = ST_DRIVE;
        ST_DRIVE: begin
          if (w_all_valid) begin
            w_state_next = ST_CAPTURE;
          end else if (w_timeout) begin
            w_state_next    = ST_ERROR;
            w_err_code_next = ERR_TIMEOUT;
          end
        end
        ST_CAPTURE: w_state_next = ST_CLEAR;
        ST_CLEAR: begin
          if (w_all_empty) begin
            w_state_next = ST_IDLE;
          end else if (w_timeout) begin
            w_state_next    = ST_ERROR;
            w_err_code_next = ERR_TIMEOUT;
          end
        end
        ST_ERROR: begin
          if (clear_err && w_all_empty) begin
            w_state_next    = ST_IDLE;
            w_err_code_next = ERR_NONE;
          end
        end
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  // The phase counter restarts on every state change and saturates at TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_vin       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= (r_state == ST_CAPTURE);
      if (r_state == ST_CAPTURE) r_res_data <= w_result;

      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == ST_DRIVE || r_state == ST_CLEAR) && r_cnt != CW'(TIMEOUT)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (r_state == ST_IDLE && w_state_next == ST_DRIVE) begin
        r_vin <= w_enc;
      end else if (w_state_next != ST_DRIVE && w_state_next != ST_CAPTURE) begin
        r_vin <= '0;
      end
    end
  end

  always_comb begin
    in_ready  = w_in_ready && !reset;
    vin       = r_vin;
    res_valid = r_res_valid;
    res_data  = r_res_data;
    err       = (r_state == ST_ERROR);
    err_code  = r_err_code;
  end

endmodule

// File: tb/tb_ycfsm_driver.sv
// Bench for ycfsm_driver: a behavioural cell column (per-cell delay, optional
// inversion, stuck-empty and illegal overrides) feeds vout back from vin.
module tb_ycfsm_driver;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int TO   = 255;

  logic           clk = 1'b0;
  logic           reset, in_valid, clear_err;
  logic           in_ready, res_valid, err;
  logic [N-1:0]   in_data, res_data;
  logic [2*N-1:0] vin, vout;
  logic [1:0]     err_code;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ycfsm_driver #(.N(N), .SYNC_STAGES(SYNC), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .vin       (vin),
    .vout      (vout),
    .res_valid (res_valid),
    .res_data  (res_data),
    .err       (err),
    .err_code  (err_code),
    .clear_err (clear_err)
  );

  // Column model: cell i answers with its input pair delayed dly[i] cycles,
  // rails swapped when it inverts, or overridden to empty / illegal.
  logic [2*N-1:0] hist [8];
  int             dly [N] = '{3, 3, 3, 3};
  logic [N-1:0]   inv_mask   = '0;
  logic [N-1:0]   stuck_mask = '0;
  logic [N-1:0]   ill_mask   = '0;
  logic           col_rst;

  always @(posedge clk) begin
    if (col_rst) begin
      for (int k = 0; k < 8; k++) hist[k] <= '0;
    end else begin
      hist[0] <= vin;
      for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
    end
  end

  always_comb begin
    vout = '0;
    for (int i = 0; i < N; i++) begin
      vout[2*i +: 2] = hist[dly[i]-1][2*i +: 2];
      if (inv_mask[i])   vout[2*i +: 2] = {hist[dly[i]-1][2*i], hist[dly[i]-1][2*i+1]};
      if (stuck_mask[i]) vout[2*i +: 2] = 2'b00;
      if (ill_mask[i])   vout[2*i +: 2] = 2'b11;
    end
  end

  logic [N-1:0] res_q [$];
  always @(negedge clk) if (res_valid === 1'b1) res_q.push_back(res_data);

  // Reference: each cell forwards its bit, inverting cells complement it.
  function automatic logic [N-1:0] col_ref(input logic [N-1:0] w);
    return w ^ inv_mask;
  endfunction

  task automatic send(input logic [N-1:0] w, output bit ok);
    in_data  = w;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [N-1:0] r, output bit ok);
    ok = 1'b0;
    r  = 'x;
    for (int c = 0; c < 400 && !ok; c++) begin
      if (res_q.size() > 0) begin
        r  = res_q.pop_front();
        ok = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s: in_ready never returned to 1", name); end
  endtask

  task automatic recover(input string name);
    clear_err = 1'b1;
    for (int c = 0; c < 100 && err === 1'b1; c++) begin @(posedge clk); #1; end
    clear_err = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL %s_clear: err=%b want 0", name, err); end
    n_tests++;
    if (err_code !== 2'b00) begin n_fail++; $display("FAIL %s_code: err_code=%b want 00", name, err_code); end
  endtask

  task automatic test_reset();
    n_tests++; if (vin !== '0)         begin n_fail++; $display("FAIL reset_vin: got %b want 0", vin); end
    n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_tests++; if (res_data !== '0)    begin n_fail++; $display("FAIL reset_res_data: got %b want 0", res_data); end
    n_tests++; if (err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_tests++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err_code: got %b want 00", err_code); end
    @(posedge clk); #1;
    reset   = 1'b0;
    col_rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_loopback();
    bit ok;
    int c;
    res_q.delete();
    send(4'b1010, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL loop_accept: word not accepted"); end
    n_tests++; if (vin !== 8'b10011001) begin n_fail++; $display("FAIL loop_vin: got %b want 10011001", vin); end
    for (c = 0; c < 60 && res_valid !== 1'b1; c++) begin @(posedge clk); #1; end
    n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL loop_res_valid: no pulse within 60 cycles"); end
    n_tests++; if (res_data !== 4'b1010) begin n_fail++; $display("FAIL loop_res_data: got %b want 1010", res_data); end
    @(posedge clk); #1;
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL loop_pulse_width: res_valid=%b want 0", res_valid); end
    wait_ready("loop_ready");
    n_tests++; if (res_q.size() != 1) begin n_fail++; $display("FAIL loop_pulse_count: got %0d want 1", res_q.size()); end
    res_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [N-1:0] r;
    res_q.delete();
    send(4'b0000, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_accept0: word not accepted"); end
    in_data  = 4'b1111;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && in_ready !== 1'b1; c++) begin @(posedge clk); #1; end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: in_ready stuck at %b", in_ready); end
    n_tests++; if (res_q.size() != 1) begin n_fail++; $display("FAIL b2b_order: %0d results before second accept, want 1", res_q.size()); end
    n_tests++; if (vin !== '0) begin n_fail++; $display("FAIL b2b_idle_vin: got %b want 0", vin); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_tests++; if (vin !== 8'b10101010) begin n_fail++; $display("FAIL b2b_vin1: got %b want 10101010", vin); end
    wait_result(r, ok);
    n_tests++; if (!ok || r !== 4'b0000) begin n_fail++; $display("FAIL b2b_res0: got %b want 0000", r); end
    wait_result(r, ok);
    n_tests++; if (!ok || r !== 4'b1111) begin n_fail++; $display("FAIL b2b_res1: got %b want 1111", r); end
    wait_ready("b2b_ready_end");
  endtask

  task automatic test_timeout();
    bit ok;
    res_q.delete();
    stuck_mask = 4'b0100;
    send(4'($urandom), ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL to_accept: word not accepted"); end
    repeat (TO - 1) begin @(posedge clk); #1; end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_early: err=%b before %0d cycles", err, TO); end
    @(posedge clk); #1;
    n_tests++; if (err !== 1'b1)       begin n_fail++; $display("FAIL to_err: got %b want 1", err); end
    n_tests++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL to_code: got %b want 01", err_code); end
    n_tests++; if (vin !== '0)         begin n_fail++; $display("FAIL to_vin: got %b want 0", vin); end
    clear_err = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_hold: err=%b want 1 while svout busy", err); end
    n_tests++; if (res_q.size() != 0) begin n_fail++; $display("FAIL to_partial: %0d results, want 0", res_q.size()); end
    stuck_mask = '0;
    recover("to");
    wait_ready("to_ready");
  endtask

  task automatic test_illegal();
    bit ok;
    int c;
    stuck_mask = 4'b0100;
    send(4'($urandom), ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ill_accept: word not accepted"); end
    repeat (5) begin @(posedge clk); #1; end
    ill_mask = 4'b0001;
    for (c = 0; c < SYNC + 1 && err !== 1'b1; c++) begin @(posedge clk); #1; end
    n_tests++; if (err !== 1'b1)       begin n_fail++; $display("FAIL ill_err: err=%b after %0d cycles", err, c); end
    n_tests++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL ill_code: got %b want 10", err_code); end
    ill_mask   = '0;
    stuck_mask = '0;
    recover("ill");
    wait_ready("ill_ready");

    // Illegal reaches the FSM in exactly the cycle the timeout would fire.
    stuck_mask = 4'b0100;
    send(4'($urandom), ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL prio_accept: word not accepted"); end
    repeat (TO - 3) begin @(posedge clk); #1; end
    ill_mask = 4'b0001;
    repeat (2) begin @(posedge clk); #1; end
    n_tests++; if (err !== 1'b0)       begin n_fail++; $display("FAIL prio_early: err=%b want 0", err); end
    @(posedge clk); #1;
    n_tests++; if (err !== 1'b1)       begin n_fail++; $display("FAIL prio_err: got %b want 1", err); end
    n_tests++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL prio_code: got %b want 10", err_code); end
    ill_mask   = '0;
    stuck_mask = '0;
    recover("prio");
    wait_ready("prio_ready");
  endtask

  task automatic test_reset_mid();
    bit ok;
    res_q.delete();
    send(4'($urandom), ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_accept: word not accepted"); end
    repeat (2) begin @(posedge clk); #1; end
    n_tests++; if (vin === '0) begin n_fail++; $display("FAIL rmid_driving: vin=%b, want nonzero", vin); end
    reset = 1'b1;
    #1;
    n_tests++; if (vin !== '0)         begin n_fail++; $display("FAIL rmid_vin: got %b want 0", vin); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_res_valid: got %b want 0", res_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b want 0", err); end
    wait_ready("rmid_ready");
    n_tests++; if (res_q.size() != 0) begin n_fail++; $display("FAIL rmid_result: %0d results, want 0", res_q.size()); end
  endtask

  task automatic test_random();
    bit ok;
    logic [N-1:0] w, r;
    repeat (10) begin @(posedge clk); #1; end
    foreach (dly[i]) dly[i] = $urandom_range(1, 6);
    inv_mask = 4'($urandom);
    res_q.delete();
    for (int k = 0; k < 20; k++) begin
      w = 4'($urandom);
      send(w, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rand_accept[%0d]: word %b not accepted", k, w); end
      wait_result(r, ok);
      n_tests++;
      if (!ok || r !== col_ref(w)) begin
        n_fail++;
        $display("FAIL rand_res[%0d]: word %b got %b want %b", k, w, r, col_ref(w));
      end
    end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err: got %b want 0", err); end
  endtask

  initial begin
    reset     = 1'b1;
    col_rst   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
